traj_driver: RTL and testbench

- Initiator side of the POMDP state-transition request interface. It owns the current hidden state of one simulated trajectory.
- Each step it takes an action from the policy handshake, pulses a request to the transition sampler with current state, action and a fresh 16-bit random word, then latches the sampled next state.
- It repeats until a programmed horizon is reached.
- It sits between the policy/belief logic and the state sampler in the simulation loop.

---
 rtl/pomdp_sim_pkg.sv | 32 +++
 rtl/traj_driver_lfsr16.sv | 31 +++
 rtl/traj_driver.sv | 168 ++++++++++++++++
 tb/tb_traj_driver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pomdp_sim_pkg.sv
// -----------------------------------------------------------------------------
// pomdp_sim_pkg
// Shared types and constants for the POMDP trajectory simulation loop:
//   - drv_state_e   : trajectory driver FSM states
//   - action_t      : policy action index (legal values 0..NUM_ACTIONS-1)
//   - LFSR_TAP_MASK : feedback taps of the 16-bit Fibonacci LFSR (16,14,13,11)
//   - lfsr_step()   : one LFSR shift, s <= {fb, s[15:1]}
// -----------------------------------------------------------------------------
package pomdp_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACT,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_COMMIT,
    ST_DONE,
    ST_ERR
  } drv_state_e;

  typedef logic [1:0] action_t;

  localparam int NUM_ACTIONS = 3;

  // Taps 16,14,13,11 of the right-shifting register land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/traj_driver_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR supplying random words to the transition sampler.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   advance    : shift once at the end of this cycle
//   value      : current register contents
// SEED must be nonzero, otherwise the register locks up at zero.
// -----------------------------------------------------------------------------
module lfsr16
  import pomdp_sim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] value
);

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/traj_driver.sv
// -----------------------------------------------------------------------------
// traj_driver
// Initiator side of the POMDP state-transition request interface. Owns the
// hidden state of one simulated trajectory: per step it accepts an action,
// issues a one-cycle request to the sampler (state, action, random word),
// latches the sampled next state and commits it, until the horizon is reached.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, init_state, horizon : launch a trajectory (IDLE/DONE/ERR only)
//   act_valid, act, act_ready  : policy action handshake
//   sg_en, sg_cur_state, sg_action, sg_random : registered sampler request
//   sg_new_state, sg_en_next   : sampler response
//   state_valid, state_out     : committed-state pulse and value
//   step_cnt                   : steps completed in this trajectory
//   busy, done, err            : status flags (done/err held until start)
// -----------------------------------------------------------------------------
module traj_driver
  import pomdp_sim_pkg::*;
#(
  parameter int          HORIZON_W = 8,
  parameter int          TIMEOUT   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 init_state,
  input  logic [HORIZON_W-1:0] horizon,
  input  logic                 act_valid,
  input  logic [1:0]           act,
  output logic                 act_ready,
  output logic                 sg_en,
  output logic                 sg_cur_state,
  output logic [1:0]           sg_action,
  output logic [15:0]          sg_random,
  input  logic                 sg_new_state,
  input  logic                 sg_en_next,
  output logic                 state_valid,
  output logic                 state_out,
  output logic [HORIZON_W-1:0] step_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  drv_state_e           state;
  logic                 cur_state;
  logic [HORIZON_W-1:0] horizon_r;
  logic [TMR_W-1:0]     timer;
  logic [TMR_W-1:0]     timer_inc;
  logic [15:0]          lfsr_value;

  assign timer_inc = timer + TMR_W'(1);

  // The LFSR moves exactly once per request, after its value was captured.
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(state == ST_ISSUE),
    .value  (lfsr_value)
  );

  // Outputs are registered: each transition writes the flags that belong to
  // the state being entered, so they are valid for the whole of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a control/datapath flop (no memory
      // arrays), so all of them are reset to a known value.
      state        <= ST_IDLE;
      cur_state    <= 1'b0;
      horizon_r    <= '0;
      timer        <= '0;
      act_ready    <= 1'b0;
      sg_en        <= 1'b0;
      sg_cur_state <= 1'b0;
      sg_action    <= '0;
      sg_random    <= '0;
      state_valid  <= 1'b0;
      state_out    <= 1'b0;
      step_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // One-cycle pulses default low.
      sg_en       <= 1'b0;
      state_valid <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            cur_state <= init_state;
            horizon_r <= horizon;
            step_cnt  <= '0;
            err       <= 1'b0;
            if (horizon == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_WAIT_ACT;
              done      <= 1'b0;
              act_ready <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end

        ST_WAIT_ACT: begin
          if (act_valid) begin
            act_ready <= 1'b0;
            if (act >= action_t'(NUM_ACTIONS)) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state        <= ST_ISSUE;
              sg_en        <= 1'b1;
              sg_cur_state <= cur_state;
              sg_action    <= act;
              sg_random    <= lfsr_value;
            end
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT_RSP;
          timer <= '0;
        end

        // sg_* are left untouched here so the sampler sees stable inputs.
        ST_WAIT_RSP: begin
          if (sg_en_next) begin
            state       <= ST_COMMIT;
            cur_state   <= sg_new_state;
            state_valid <= 1'b1;
            state_out   <= sg_new_state;
            step_cnt    <= step_cnt + HORIZON_W'(1);
          end else begin
            timer <= timer_inc;
            if (timer_inc == TMR_LAST) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          // step_cnt already holds the incremented count in this cycle.
          if (step_cnt == horizon_r) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= ST_WAIT_ACT;
            act_ready <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traj_driver.sv
// -----------------------------------------------------------------------------
// tb_traj_driver
// Directed and randomized stimulus for traj_driver. A small reference model
// (expected LFSR word, committed state, step count) predicts every request
// and commit; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_traj_driver;

  localparam int          HW      = 8;
  localparam int          TIMEOUT = 4;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          init_state;
  logic [HW-1:0] horizon;
  logic          act_valid;
  logic [1:0]    act;
  logic          act_ready;
  logic          sg_en;
  logic          sg_cur_state;
  logic [1:0]    sg_action;
  logic [15:0]   sg_random;
  logic          sg_new_state;
  logic          sg_en_next;
  logic          state_valid;
  logic          state_out;
  logic [HW-1:0] step_cnt;
  logic          busy;
  logic          done;
  logic          err;

  traj_driver #(.HORIZON_W(HW), .TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .init_state  (init_state),
    .horizon     (horizon),
    .act_valid   (act_valid),
    .act         (act),
    .act_ready   (act_ready),
    .sg_en       (sg_en),
    .sg_cur_state(sg_cur_state),
    .sg_action   (sg_action),
    .sg_random   (sg_random),
    .sg_new_state(sg_new_state),
    .sg_en_next  (sg_en_next),
    .state_valid (state_valid),
    .state_out   (state_out),
    .step_cnt    (step_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_lfsr;   // random word the next request must carry
  logic        m_state;  // committed hidden state
  int          m_steps;  // steps completed

  // Reference LFSR: feedback from bits 0,2,3,5, shifted in at the top.
  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(fb) << 15);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] all_outs();
    return {act_ready, sg_en, sg_cur_state, sg_action, sg_random, state_valid,
            state_out, step_cnt, busy, done, err};
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    start        = 1'b0;
    init_state   = 1'b0;
    horizon      = '0;
    act_valid    = 1'b0;
    act          = '0;
    sg_en_next   = 1'b0;
    sg_new_state = 1'b0;
    #1;
    check("reset_outputs_zero", 64'(all_outs()), 64'd0);
    m_lfsr  = SEED;
    m_state = 1'b0;
    m_steps = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_traj(input logic init, input logic [HW-1:0] h);
    start      = 1'b1;
    init_state = init;
    horizon    = h;
    tick();
    start   = 1'b0;
    m_state = init;
    m_steps = 0;
    check("start_err_clear", err, 1'b0);
    check("start_step_cnt", step_cnt, 0);
    check("start_busy", busy, h != 0);
    check("start_done", done, h == 0);
  endtask

  // Full step: handshake at t, request at t+1, response at t+2, commit at t+3.
  task automatic do_step(input logic [1:0] a, input logic rsp);
    check("step_act_ready", act_ready, 1'b1);
    act_valid = 1'b1;
    act       = a;
    tick();
    act_valid = 1'b0;
    check("issue_sg_en", sg_en, 1'b1);
    check("issue_sg_random", sg_random, m_lfsr);
    check("issue_sg_action", sg_action, a);
    check("issue_sg_cur_state", sg_cur_state, m_state);
    check("issue_act_ready", act_ready, 1'b0);
    tick();
    check("wait_sg_en_low", sg_en, 1'b0);
    check("wait_sg_random_held", sg_random, m_lfsr);
    check("wait_no_state_valid", state_valid, 1'b0);
    sg_en_next   = 1'b1;
    sg_new_state = rsp;
    tick();
    sg_en_next   = 1'b0;
    sg_new_state = 1'($urandom);
    m_lfsr  = lfsr_ref(m_lfsr);
    m_state = rsp;
    m_steps++;
    check("commit_state_valid", state_valid, 1'b1);
    check("commit_state_out", state_out, m_state);
    check("commit_step_cnt", step_cnt, m_steps);
    tick();
    check("post_commit_pulse_low", state_valid, 1'b0);
  endtask

  task automatic check_done(input int h);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_act_ready", act_ready, 1'b0);
    check("end_step_cnt", step_cnt, h);
    check("end_state_out", state_out, m_state);
  endtask

  initial begin
    logic [15:0] held_rand;
    int          h;

    do_reset();
    tick();
    check("idle_outputs_zero", 64'(all_outs()), 64'd0);

    // First trajectory: one step, seed word on the wire.
    start_traj(1'b0, 8'd1);
    do_step(2'd1, 1'b1);
    check("first_word_was_seed", 64'(lfsr_ref(SEED)), 64'(m_lfsr));
    check_done(1);

    // Three steps from a fresh reset; second request carries 16'h5670.
    do_reset();
    start_traj(1'b1, 8'd3);
    do_step(2'd0, 1'b0);
    do_step(2'd2, 1'b1);
    check("second_word_literal", sg_random, 16'h5670);
    do_step(2'd1, 1'b0);
    check_done(3);

    // Zero horizon: straight to DONE, no request.
    start_traj(1'b1, 8'd0);
    check("h0_step_cnt", step_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("h0_no_sg_en", sg_en, 1'b0);
      check("h0_done_held", done, 1'b1);
    end

    // Illegal action 3 -> ERR without a request, then restart clears err.
    start_traj(1'b0, 8'd2);
    act_valid = 1'b1;
    act       = 2'd3;
    tick();
    act_valid = 1'b0;
    check("bad_act_err", err, 1'b1);
    check("bad_act_no_sg_en", sg_en, 1'b0);
    check("bad_act_busy", busy, 1'b0);
    tick();
    check("bad_act_err_held", err, 1'b1);
    start_traj(1'b1, 8'd1);
    do_step(2'd2, 1'b0);
    check_done(1);

    // Sampler never answers: err exactly TIMEOUT cycles after sg_en.
    start_traj(1'b0, 8'd1);
    act_valid = 1'b1;
    act       = 2'd2;
    tick();
    act_valid = 1'b0;
    check("to_sg_en", sg_en, 1'b1);
    held_rand = m_lfsr;
    m_lfsr    = lfsr_ref(m_lfsr);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      check("to_err_early", err, 1'b0);
      check("to_sg_random_stable", sg_random, held_rand);
      check("to_sg_action_stable", sg_action, 2'd2);
      check("to_sg_cur_state_stable", sg_cur_state, 1'b0);
    end
    tick();
    check("to_err", err, 1'b1);
    check("to_busy", busy, 1'b0);

    // Spurious response and start while busy are ignored.
    start_traj(1'b1, 8'd2);
    do_step(2'd0, 1'b0);
    sg_en_next   = 1'b1;
    sg_new_state = 1'b1;
    start        = 1'b1;
    init_state   = 1'b1;
    horizon      = 8'd0;
    tick();
    sg_en_next = 1'b0;
    start      = 1'b0;
    check("spur_state_out", state_out, m_state);
    check("spur_step_cnt", step_cnt, m_steps);
    check("spur_no_valid", state_valid, 1'b0);
    check("spur_busy", busy, 1'b1);
    check("spur_done", done, 1'b0);
    do_step(2'd1, 1'b1);
    check_done(2);

    // Reset while waiting for a response; next trajectory restarts the LFSR.
    start_traj(1'b0, 8'd1);
    act_valid = 1'b1;
    act       = 2'd0;
    tick();
    act_valid = 1'b0;
    tick();
    sg_en_next   = 1'b1;
    sg_new_state = 1'b1;
    do_reset();
    tick();
    check("after_reset_idle", 64'(all_outs()), 64'd0);
    start_traj(1'b0, 8'd1);
    do_step(2'd1, 1'b1);
    check_done(1);

    // Randomized trajectories.
    for (int t = 0; t < 10; t++) begin
      h = int'($urandom_range(1, 5));
      start_traj(1'($urandom), 8'(h));
      for (int s = 0; s < h; s++) begin
        do_step(2'($urandom_range(0, 2)), 1'($urandom));
      end
      check_done(h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
